// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed, XOR-checksummed program into instruction memory
// while holding the CPU paused.
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_pause,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR} state_t;
  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [23:0] word_q, word_d;
  logic [31:0] idx_q, idx_d, addr_q, addr_d, wdata_q, wdata_d, tmo_q, tmo_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [7:0]  csum_q, csum_d;
  logic        acc;
  assign byte_ready = state_q == LEN || state_q == DATA || state_q == CSUM;
  assign busy       = byte_ready || state_q == WRITE;
  assign cpu_pause  = busy;
  assign imem_we    = state_q == WRITE;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = state_q == DONE;
  assign err        = state_q == ERR;
  assign acc        = byte_valid && byte_ready;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tmo_d   = tmo_q;
    bcnt_d  = bcnt_q;
    csum_d  = csum_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = LEN;
        idx_d   = '0;
        bcnt_d  = '0;
        csum_d  = '0;
        tmo_d   = '0;
      end
      LEN: if (acc) begin
        len_d  = {len_q[7:0], byte_data};
        bcnt_d = bcnt_q[0] ? 2'd0 : 2'd1;
        if (bcnt_q[0]) state_d = (len_d == 16'd0 || {16'h0, len_d} > MAX_WORDS) ? ERR : DATA;
      end
      DATA: if (acc) begin
        word_d = {word_q[15:0], byte_data};
        csum_d = csum_q ^ byte_data;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          state_d = WRITE;
          addr_d  = BASE_ADDR + (idx_q << 2);
          wdata_d = {word_q, byte_data};
        end
      end
      WRITE: begin
        idx_d   = idx_q + 32'd1;
        tmo_d   = '0;
        state_d = idx_d == {16'h0, len_q} ? CSUM : DATA;
      end
      CSUM: if (acc) state_d = byte_data == csum_q ? DONE : ERR;
      default: state_d = IDLE;
    endcase
    // idle clocks between accepted bytes; the TIMEOUT-th one aborts the load
    if (byte_ready) begin
      tmo_d = acc ? 32'd0 : tmo_q + 32'd1;
      if (!acc && tmo_q + 32'd1 == TIMEOUT) state_d = ERR;
    end
  end
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
      bcnt_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
      bcnt_q  <= bcnt_d;
      csum_q  <= csum_d;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed program loads; expected imem writes go through a scoreboard queue.
module tb_program_loader;
  logic        clk = 1'b0, rst_n, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, cpu_pause, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  int          total = 0, bad = 0;
  logic [63:0] exp_q[$];

  program_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(256), .TIMEOUT(16)) dut (
    .CLOCK_50(clk), .reset(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_pause(cpu_pause), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (imem_we) begin
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_write got=%h:%h want=none", imem_addr, imem_wdata);
    end else begin
      logic [63:0] e;
      e = exp_q.pop_front();
      if ({imem_addr, imem_wdata} !== e) begin
        bad++;
        $display("FAIL imem_write got=%h:%h want=%h:%h", imem_addr, imem_wdata, e[63:32], e[31:0]);
      end
    end
    chk("ready_in_write", byte_ready, 0);
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_ready_timeout", 1, 0);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic word(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
    for (int i = 3; i >= 0; i--) send(d[i*8 +: 8]);
  endtask

  task automatic go();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_busy", busy, 0);
    chk("done_err_excl", done & err, 0);
  endtask

  task automatic chk_reset();
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_pause", cpu_pause, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #12 chk_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ready", byte_ready, 0);
    // single word program
    go();
    chk("t1_busy", busy, 1);
    chk("t1_pause", cpu_pause, 1);
    send(8'h00); send(8'h01);
    word(32'h0, 32'h2008_0005);
    send(8'h2D);
    wait_idle();
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_pause_low", cpu_pause, 0);
    chk("t1_addr_hold", imem_addr, 32'h0);
    chk("t1_wdata_hold", imem_wdata, 32'h2008_0005);
    // two words, good checksum
    go();
    chk("t2_done_cleared", done, 0);
    send(8'h00); send(8'h02);
    word(32'h0, 32'h1122_3344);
    word(32'h4, 32'h5566_7788);
    send(8'h88);
    wait_idle();
    chk("t2_done", done, 1);
    chk("t2_err", err, 0);
    chk("t2_addr_hold", imem_addr, 32'h4);
    // two words, bad checksum
    go();
    send(8'h00); send(8'h02);
    word(32'h0, 32'h1122_3344);
    word(32'h4, 32'h5566_7788);
    send(8'h00);
    wait_idle();
    chk("t3_err", err, 1);
    chk("t3_done", done, 0);
    // illegal lengths
    go();
    send(8'h00); send(8'h00);
    @(negedge clk);
    chk("len0_err", err, 1);
    chk("len0_busy", busy, 0);
    go();
    chk("restart_err_cleared", err, 0);
    send(8'h01); send(8'h01);
    @(negedge clk);
    chk("len257_err", err, 1);
    go();
    send(8'h01); send(8'h00);
    @(negedge clk);
    chk("len256_busy", busy, 1);
    chk("len256_err", err, 0);
    rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk) rst_n = 1'b1;
    // stall mid-word until timeout
    go();
    send(8'h00); send(8'h01); send(8'h11); send(8'h22);
    repeat (15) @(posedge clk);
    #1 chk("tmo_not_yet", busy, 1);
    @(posedge clk);
    #1 chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_pause", cpu_pause, 0);
    // valid held low through WRITE
    go();
    send(8'h00); send(8'h01);
    exp_q.push_back({32'h0, 32'hA1B2_C3D4});
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    @(negedge clk);
    chk("wr_we", imem_we, 1);
    chk("wr_ready", byte_ready, 0);
    send(8'h04);
    wait_idle();
    chk("wr_done", done, 1);
    // reset mid-load, then full reload
    go();
    send(8'h00); send(8'h03);
    word(32'h0, 32'h0102_0304);
    word(32'h4, 32'h0506_0708);
    send(8'h09);
    #3 rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", byte_ready, 0);
    go();
    send(8'h00); send(8'h03);
    word(32'h0, 32'h0102_0304);
    word(32'h4, 32'h0506_0708);
    word(32'h8, 32'h090A_0B0C);
    send(8'h0C);
    wait_idle();
    chk("t6_done", done, 1);
    chk("t6_err", err, 0);
    chk("t6_addr_hold", imem_addr, 32'h8);
    repeat (2) @(negedge clk);
    chk("writes_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
